data_mem_arbiter: RTL
=====================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port HACK data_mem (RAM + memory-mapped IO registers) between two requesters:
//  m0 = HACK CPU data port, m1 = loader/debug port.
//  Round-robin arbitration, optional bus lock with a bounded hold time, and a 1-cycle read-response return path.
//  Sits between the CPU/loader and data_mem; data_mem connects directly to the mem_* ports.
// PARAMETERS
//  AW        15  address width (data_mem address space incl. 0x7000/0x7400 IO regs)
//  DW        16  data word width
//  MAX_HOLD  8   max consecutive cycles a locked owner keeps the bus while the other master requests (>=1)
// PORTS
//  clk50m    in   1   system clock, all logic on rising edge
//  rst       in   1   reset, asynchronous, active-high
//  m0_req    in   1   m0 access request (held until m0_gnt)
//  m0_we     in   1   m0 write enable (1=write, 0=read)
//  m0_lock   in   1   m0 requests bus ownership for back-to-back accesses
//  m0_addr   in   AW  m0 address
//  m0_wdata  in   DW  m0 write data
//  m0_gnt    out  1   m0 access accepted this cycle
//  m0_rvalid out  1   m0 read data valid on rdata
//  m1_*      —    —   identical set for m1
//  rdata     out  DW  read data, shared (= mem_dout), qualified by mx_rvalid
//  mem_we    out  1   to data_mem we
//  mem_addr  out  AW  to data_mem addr
//  mem_din   out  DW  to data_mem data_in
//  mem_dout  in   DW  from data_mem data_out, valid 1 cycle after read address applied
// BEHAVIOUR
//  - Reset (async, rst=1):
//    state=IDLE, last=1 (m0 wins first tie), hold_cnt=0, m0/m1_rvalid=0.
//    gnt=0 and mem_we=0 while rst high; mem_addr/mem_din=0.
//  - Grant is combinational in the cycle of the access. Only the granted master drives mem_*.
//    With no grant: mem_we=0, mem_addr/mem_din hold 0.
//  - At most one gnt per cycle. Write completes on the grant edge. Read: mx_rvalid=1 exactly the cycle after the read grant.
//  - States: IDLE, OWN0, OWN1.
//  - IDLE:
//    - one requester -> grant it;
//    - both -> grant the master != last;
//    - none -> no grant.
//    - Winner x: last<=x. If mx_lock=1 at grant -> OWNx with hold_cnt<=1, else stay IDLE.
//  - OWNx (y = other master):
//    - mx_req=1 -> grant x, hold_cnt++ (saturating).
//    - mx_lock=0 in a cycle -> that cycle is arbitrated as IDLE (x keeps priority if mx_req=1), next state per IDLE rule.
//    - mx_req=0 and mx_lock=1 -> no grant (y blocked), hold_cnt++.
//    - Forced release: hold_cnt>=MAX_HOLD and my_req=1 -> grant y this cycle, last<=y, x is not granted.
//      Next state OWNy if my_lock else IDLE; hold_cnt<=1 or 0 accordingly.
//    - hold_cnt is not compared while my_req=0; owner may exceed MAX_HOLD when uncontended.
//  - A master never gets two grants for one request unless it keeps req high (each high cycle with gnt = one access).
//  - Reset mid-read: the pending rvalid is dropped. No rvalid after rst deasserts until a new read grant.
//  - rdata = mem_dout combinationally. No registering, so data_mem read latency (1) is the total read latency.
// TESTING
//  1. Reset: rst=1 for 5 clk while m0_req=m1_req=1 -> no gnt, mem_we=0, rvalid=0.
//     Release -> first grant m0.
//  2. m0 write 0x0000<=0xFFFF, then m0 read 0x0000 -> m0_gnt both cycles.
//     m0_rvalid one cycle after the read grant, rdata=0xFFFF, m1_rvalid=0.
//  3. Both request reads continuously, no lock -> grants alternate m0,m1,m0,m1.
//     Each rvalid follows its own grant by 1 cycle.
//  4. m1 lock + req burst of 20 writes to 0x3000.., m0_req high from the 2nd cycle, MAX_HOLD=8 -> m1 gets 8 grants, m0 granted on cycle 9.
//     Then the m1 burst resumes (m0 unlocked).
//  5. m1 write 0x7002<=0xFFFF -> mem_we pulse 1 cycle, addr 0x7002.
//     Data_mem IO reg 0x7002 output = 0xFFFF the next cycle.
//  6. m0 read granted, rst asserted before the next edge -> m0_rvalid stays 0. State IDLE after release.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: two requester ports (m0 CPU, m1 loader) plus the data_mem bus
// slave  : arbiter side (takes m0_*/m1_* requests and mem_dout; drives grants, rvalid, rdata, mem_*)
// master : requester/memory side (mirror image)
interface data_mem_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 16
);
  logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] rdata, mem_din, mem_dout;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata, mem_dout,
    output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata, mem_we, mem_addr, mem_din
  );
  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata, mem_dout,
    input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter with bounded bus lock sharing data_mem between m0 and m1
// clk50m/rst : clock, async active-high reset
// bus        : slave modport carrying both requester ports and the data_mem bus
module data_mem_arbiter #(
  parameter int AW       = 15,
  parameter int DW       = 16,
  parameter int MAX_HOLD = 8
) (
  input logic               clk50m,
  input logic               rst,
  data_mem_arbiter_if.slave bus
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    rv_q;
  logic [1:0]    req, we, lock, gnt;
  logic          own, o, forced, arb, w, g;
  assign req  = {bus.m1_req, bus.m0_req};
  assign we   = {bus.m1_we, bus.m0_we};
  assign lock = {bus.m1_lock, bus.m0_lock};
  // An unlocked owner cycle is arbitrated like IDLE, except the owner keeps priority on a tie;
  // a locked owner yields only once it has held the bus MAX_HOLD cycles and the other side waits.
  always_comb begin
    own     = state_q != IDLE;
    o       = state_q == OWN1;
    forced  = own && lock[o] && hold_q >= HW'(MAX_HOLD) && req[~o];
    arb     = !own || !lock[o];
    w       = arb ? (&req ? (own ? o : ~last_q) : req[1]) : (forced ? ~o : o);
    g       = arb ? |req : (forced || req[o]);
    gnt     = {g && w, g && !w} & {2{!rst}};
    last_d  = g ? w : last_q;
    state_d = (arb || forced) ? ((g && lock[w]) ? (w ? OWN1 : OWN0) : IDLE) : state_q;
    hold_d  = (arb || forced) ? HW'(g && lock[w]) :
              (hold_q == HW'(MAX_HOLD) ? hold_q : hold_q + HW'(1));
  end
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
      rv_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      rv_q    <= gnt & ~we;
    end
  end
  assign bus.m0_gnt    = gnt[0];
  assign bus.m1_gnt    = gnt[1];
  assign bus.m0_rvalid = rv_q[0];
  assign bus.m1_rvalid = rv_q[1];
  assign bus.rdata     = bus.mem_dout;
  assign bus.mem_we    = |(gnt & we);
  assign bus.mem_addr  = gnt[1] ? bus.m1_addr : (gnt[0] ? bus.m0_addr : '0);
  assign bus.mem_din   = gnt[1] ? bus.m1_wdata : (gnt[0] ? bus.m0_wdata : '0);
endmodule
